// File: rtl/bfly_pkg.sv
// Shared constants for the radix-2 butterfly datapath.
// Holds the default word format and the phase numbering.
package bfly_pkg;

  localparam int DEFAULT_WORD_SIZE = 16;
  localparam int DEFAULT_FRACTION  = 8;

  // Phase number doubles as the slot index of the product that arrives in that phase.
  localparam logic [1:0] PH_RR = 2'd0;
  localparam logic [1:0] PH_IR = 2'd1;
  localparam logic [1:0] PH_RI = 2'd2;
  localparam logic [1:0] PH_II = 2'd3;

endpackage

// File: rtl/bfly_serial_combine_if.sv
// Bus between the butterfly multiplier side and the serial combine stage.
// The master drives the products and in0; the slave returns the phase and the results.
interface bfly_serial_combine_if #(
  parameter int WORD_SIZE = bfly_pkg::DEFAULT_WORD_SIZE
);

  logic [WORD_SIZE-1:0] i_product;
  logic [WORD_SIZE-1:0] i_in0_re;
  logic [WORD_SIZE-1:0] i_in0_im;
  logic [1:0]           o_phase;
  logic [WORD_SIZE-1:0] o_out0_re;
  logic [WORD_SIZE-1:0] o_out0_im;
  logic [WORD_SIZE-1:0] o_out1_re;
  logic [WORD_SIZE-1:0] o_out1_im;
  logic                 o_done;

  modport master (
    output i_product, i_in0_re, i_in0_im,
    input  o_phase, o_out0_re, o_out0_im, o_out1_re, o_out1_im, o_done
  );

  modport slave (
    input  i_product, i_in0_re, i_in0_im,
    output o_phase, o_out0_re, o_out0_im, o_out1_re, o_out1_im, o_done
  );

endinterface

// File: rtl/bfly_serial_combine_sum3_wrap.sv
// Registered three-operand adder that wraps modulo 2^WORD_SIZE.
// Loads only when enabled; callers pass already-negated operands.
module sum3_wrap #(
  parameter int WORD_SIZE = bfly_pkg::DEFAULT_WORD_SIZE
) (
  input  logic                 clk_divided8,
  input  logic                 i_rst,
  input  logic                 en,
  input  logic [WORD_SIZE-1:0] a,
  input  logic [WORD_SIZE-1:0] b,
  input  logic [WORD_SIZE-1:0] c,
  output logic [WORD_SIZE-1:0] sum
);

  always_ff @(posedge clk_divided8 or posedge i_rst) begin
    if (i_rst) begin
      sum <= '0;
    end else if (en) begin
      sum <= a + b + c;
    end
  end

endmodule

// File: rtl/bfly_serial_combine.sv
// Collects the four partial products of in1*W one per cycle and
// combines them with in0 into both butterfly outputs once per frame.
module bfly_serial_combine
  import bfly_pkg::*;
#(
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
  parameter int FRACTION  = DEFAULT_FRACTION
) (
  input logic                  clk_divided8,
  input logic                  i_rst,
  bfly_serial_combine_if.slave bus
);

  typedef logic [WORD_SIZE-1:0] word_t;

  localparam word_t ONE = word_t'(1);

  // FRACTION only names the Q format, but it still has to fit inside a word.
  if (FRACTION < 0 || FRACTION >= WORD_SIZE) begin : g_bad_fraction
    $error("FRACTION must lie inside WORD_SIZE");
  end

  word_t      slot [4];
  logic [1:0] phase;
  logic       frame_full;
  logic       load;
  logic       done;

  // frame_full keeps the first phase-0 edge after reset from publishing an empty frame.
  always_ff @(posedge clk_divided8 or posedge i_rst) begin
    if (i_rst) begin
      for (int s = 0; s < 4; s++) begin
        slot[s] <= '0;
      end
      phase      <= PH_RR;
      frame_full <= 1'b0;
      done       <= 1'b0;
    end else begin
      slot[phase] <= bus.i_product;
      phase       <= phase + 2'd1;
      if (phase == PH_II) begin
        frame_full <= 1'b1;
      end
      done <= load;
    end
  end

  assign load = (phase == PH_RR) && frame_full;

  word_t neg_rr, neg_ir, neg_ri, neg_ii;

  assign neg_rr = ~slot[PH_RR] + ONE;
  assign neg_ir = ~slot[PH_IR] + ONE;
  assign neg_ri = ~slot[PH_RI] + ONE;
  assign neg_ii = ~slot[PH_II] + ONE;

  // The load edge also overwrites slot RR, so the adders see the old frame's RR.
  sum3_wrap #(.WORD_SIZE(WORD_SIZE)) u_out0_re (
    .clk_divided8(clk_divided8), .i_rst(i_rst), .en(load),
    .a(bus.i_in0_re), .b(slot[PH_RR]), .c(neg_ii), .sum(bus.o_out0_re)
  );

  sum3_wrap #(.WORD_SIZE(WORD_SIZE)) u_out0_im (
    .clk_divided8(clk_divided8), .i_rst(i_rst), .en(load),
    .a(bus.i_in0_im), .b(slot[PH_IR]), .c(slot[PH_RI]), .sum(bus.o_out0_im)
  );

  sum3_wrap #(.WORD_SIZE(WORD_SIZE)) u_out1_re (
    .clk_divided8(clk_divided8), .i_rst(i_rst), .en(load),
    .a(bus.i_in0_re), .b(neg_rr), .c(slot[PH_II]), .sum(bus.o_out1_re)
  );

  sum3_wrap #(.WORD_SIZE(WORD_SIZE)) u_out1_im (
    .clk_divided8(clk_divided8), .i_rst(i_rst), .en(load),
    .a(bus.i_in0_im), .b(neg_ir), .c(neg_ri), .sum(bus.o_out1_im)
  );

  assign bus.o_phase = phase;
  assign bus.o_done  = done;

endmodule

// File: tb/tb_bfly_serial_combine.sv
// Randomized bench for bfly_serial_combine against a frame-level model,
// with literal checks for the nominal, wrap, most-negative and reset cases.
module tb_bfly_serial_combine;
  import bfly_pkg::*;

  localparam int W = DEFAULT_WORD_SIZE;
  typedef logic [W-1:0] word_t;

  logic clk_divided8 = 1'b0;
  logic i_rst        = 1'b1;
  int   checks       = 0;
  int   failures     = 0;
  bit   started      = 1'b0;

  bfly_serial_combine_if #(.WORD_SIZE(W)) bus ();

  bfly_serial_combine #(.WORD_SIZE(W), .FRACTION(DEFAULT_FRACTION)) dut (
    .clk_divided8(clk_divided8),
    .i_rst(i_rst),
    .bus(bus)
  );

  always #5 clk_divided8 = ~clk_divided8;

  // Model: every sampled product and in0 since reset, indexed by edge number - 1.
  word_t prods[$];
  word_t in0r_q[$];
  word_t in0i_q[$];
  int    n = 0;

  always @(posedge clk_divided8 or posedge i_rst) begin
    if (i_rst) begin
      prods.delete();
      in0r_q.delete();
      in0i_q.delete();
      n = 0;
    end else begin
      prods.push_back(bus.i_product);
      in0r_q.push_back(bus.i_in0_re);
      in0i_q.push_back(bus.i_in0_im);
      n = n + 1;
    end
  end

  function automatic void combine(input word_t i0r, i0i, rr, ir, ri, ii,
                                  output word_t o0r, o0i, o1r, o1i);
    o0r = i0r + rr - ii;
    o0i = i0i + ir + ri;
    o1r = i0r - rr + ii;
    o1i = i0i - ir - ri;
  endfunction

  function automatic word_t rnd_word();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'h0000;
      3:       return 16'hFFFF;
      default: return word_t'($urandom);
    endcase
  endfunction

  task automatic check_output(input string name, input word_t got, input word_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h (edge %0d)", name, got, exp, n);
    end
  endtask

  task automatic apply_stimulus(input word_t p);
    bus.i_product = p;
    @(negedge clk_divided8);
  endtask

  // Frame f is sampled on edges 4f+1..4f+4 and published on edge 4f+5 with that edge's in0.
  always @(negedge clk_divided8) begin
    if (started && !i_rst) begin
      word_t e0r, e0i, e1r, e1i;
      int f;
      e0r = '0; e0i = '0; e1r = '0; e1i = '0;
      if (n >= 5) begin
        f = (n - 1) / 4 - 1;
        combine(in0r_q[4*f+4], in0i_q[4*f+4], prods[4*f], prods[4*f+1],
                prods[4*f+2], prods[4*f+3], e0r, e0i, e1r, e1i);
      end
      check_output("phase", word_t'(bus.o_phase), word_t'(n % 4));
      check_output("done", word_t'(bus.o_done), word_t'((n >= 5) && (n % 4 == 1)));
      check_output("out0_re", bus.o_out0_re, e0r);
      check_output("out0_im", bus.o_out0_im, e0i);
      check_output("out1_re", bus.o_out1_re, e1r);
      check_output("out1_im", bus.o_out1_im, e1i);
    end
  end

  initial begin
    bus.i_product = '0;
    bus.i_in0_re  = '0;
    bus.i_in0_im  = '0;
    repeat (2) @(negedge clk_divided8);
    started = 1'b1;
    check_output("rst_phase", word_t'(bus.o_phase), 16'h0000);
    check_output("rst_done", word_t'(bus.o_done), 16'h0000);
    check_output("rst_out0_re", bus.o_out0_re, 16'h0000);
    check_output("rst_out1_im", bus.o_out1_im, 16'h0000);
    i_rst = 1'b0;

    // Nominal frame; in0 must stay put through the publishing edge.
    bus.i_in0_re = 16'h0100;
    bus.i_in0_im = 16'h0000;
    apply_stimulus(16'h0080);
    apply_stimulus(16'h0040);
    apply_stimulus(16'h0020);
    apply_stimulus(16'h0010);
    apply_stimulus(16'h0200);
    check_output("nom_done", word_t'(bus.o_done), 16'h0001);
    check_output("nom_out0_re", bus.o_out0_re, 16'h0170);
    check_output("nom_out0_im", bus.o_out0_im, 16'h0060);
    check_output("nom_out1_re", bus.o_out1_re, 16'h0090);
    check_output("nom_out1_im", bus.o_out1_im, 16'hFFA0);

    // Wrap frame: RR=0x0200 was taken on the previous edge.
    bus.i_in0_re = 16'h7F00;
    bus.i_in0_im = rnd_word();
    apply_stimulus(rnd_word());
    apply_stimulus(rnd_word());
    apply_stimulus(16'h0000);
    apply_stimulus(16'h8000);
    check_output("wrap_out0_re", bus.o_out0_re, 16'h8100);
    check_output("wrap_out1_re", bus.o_out1_re, 16'h7D00);

    // Most-negative RR frame.
    bus.i_in0_re = 16'h0000;
    apply_stimulus(rnd_word());
    apply_stimulus(rnd_word());
    apply_stimulus(16'h0000);
    apply_stimulus(rnd_word());
    check_output("mneg_out0_re", bus.o_out0_re, 16'h8000);
    check_output("mneg_out1_re", bus.o_out1_re, 16'h8000);

    for (int c = 0; c < 100; c++) begin
      if (n % 4 == 1) begin
        bus.i_in0_re = rnd_word();
        bus.i_in0_im = rnd_word();
      end
      apply_stimulus(rnd_word());
    end

    for (int c = 0; c < 4 && n % 4 != 2; c++) begin
      apply_stimulus(rnd_word());
    end
    check_output("pre_rst_phase", word_t'(bus.o_phase), 16'h0002);
    #2 i_rst = 1'b1;
    #1;
    check_output("mid_rst_phase", word_t'(bus.o_phase), 16'h0000);
    check_output("mid_rst_done", word_t'(bus.o_done), 16'h0000);
    check_output("mid_rst_out0_re", bus.o_out0_re, 16'h0000);
    check_output("mid_rst_out0_im", bus.o_out0_im, 16'h0000);
    check_output("mid_rst_out1_re", bus.o_out1_re, 16'h0000);
    check_output("mid_rst_out1_im", bus.o_out1_im, 16'h0000);
    @(negedge clk_divided8);
    i_rst = 1'b0;

    for (int c = 0; c < 60; c++) begin
      if (n % 4 == 1) begin
        bus.i_in0_re = rnd_word();
        bus.i_in0_im = rnd_word();
      end
      apply_stimulus(rnd_word());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bfly_serial_combine.md
# bfly_serial_combine

Serial product-collection and combine stage of the radix-2 butterfly. The upstream multiplier delivers the four partial products of in1 × twiddle one per cycle, in a fixed phase order. This block stores each product in a 4-slot register file and forms both butterfly outputs with registered 3-input wrap-around adders. It also owns the 2-bit phase counter that sequences the upstream operand muxes.

## Interface
- WORD_SIZE, 16: width of every data word (two's complement).
- FRACTION, 8: fractional bits of the Q format. Documents the format only; no arithmetic in this block depends on it.

Ports:
- clk_divided8  in  1  block clock, one product slot per rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_product  in  WORD_SIZE  current partial product from the multiplier
- i_in0_re, i_in0_im  in  WORD_SIZE  butterfly input 0, held stable by the producer for the whole frame
- o_phase  out  2  current phase; drives the upstream selects (bit0 selects in1 re/im, bit1 selects twiddle re/im)
- o_out0_re, o_out0_im  out  WORD_SIZE  in0 + in1·W
- o_out1_re, o_out1_im  out  WORD_SIZE  in0 − in1·W
- o_done  out  1  one-cycle pulse marking new valid outputs

## Operation
- Phase order and slot mapping, i_product at each phase:
  - 0: in1_re·tw_re, stored in slot RR
  - 1: in1_im·tw_re, stored in slot IR
  - 2: in1_re·tw_im, stored in slot RI
  - 3: in1_im·tw_im, stored in slot II
- On each edge, slot[o_phase] <= i_product, then o_phase <= o_phase+1 (mod 4; 3 wraps to 0). The other slots hold their values.
- Combine equations, all mod 2^WORD_SIZE:
  - out0_re = in0_re + RR − II
  - out0_im = in0_im + IR + RI
  - out1_re = in0_re − RR + II
  - out1_im = in0_im − IR − RI
- Negation is two's complement (~x+1) with wrap: −0x8000 = 0x8000 for WORD_SIZE 16. There is no saturation, rounding or overflow flag.
- Output registers load only on an edge where o_phase==0, i.e. after a complete frame has been written. At all other times they hold their value.

## Timing
- Frame = 4 cycles. Products are sampled at edges k..k+3 (phases 0..3).
- Outputs update at edge k+4. That edge also samples i_in0_* and writes the next frame's phase-0 product; the adders use the old RR value.
- o_done is high for exactly the cycle after each output update, i.e. the cycle in which o_phase==1. The first pulse follows the first complete frame after reset.
- Reset (async assert): o_phase=0, all slots=0, all outputs=0, o_done=0.
- Reset asserted mid-frame: the partial frame is discarded and there is no o_done pulse for it. After release, the sequence restarts at phase 0.
- Release of i_rst is synchronized to clk_divided8 by the integrator.

## Structure
- Shared package bfly_pkg holds:
  - the default WORD_SIZE and FRACTION
  - phase constants PH_RR=2'd0, PH_IR=2'd1, PH_RI=2'd2, PH_II=2'd3
- Sub-module sum3_wrap: registered A+B+C, WORD_SIZE wide, async reset to 0, with a load enable. Four instances are used. Negated operands are formed in the parent.
- The slot file and phase counter are inline.

## Test plan
Values use WORD_SIZE=16, FRACTION=8.
- Nominal frame: in0=(0x0100, 0x0000); products 0x0080, 0x0040, 0x0020, 0x0010 -> out0=(0x0170, 0x0060), out1=(0x0090, 0xFFA0). o_done pulses once, 1 cycle after phase-3 sampling +1 edge.
- Wrap: in0_re=0x7F00, RR=0x0200, II=0 -> out0_re=0x8100, out1_re=0x7D00.
- Most-negative: in0_re=0, RR=0x8000, II=0 -> out0_re=0x8000, out1_re=0x8000.
- Steady stream of 5 frames: o_phase cycles 0,1,2,3 and o_done has period exactly 4. Each frame's outputs match the equations and are unaffected by the previous frame's slots.
- Reset at phase 2: outputs and o_done are 0 immediately (async). After release the first o_done comes only after 4 new products, with results from the new products only.
